// File: rtl/alu_reservation_station.sv
// Tomasulo ALU reservation station: buffers micro-ops, snoops both CDBs, issues one per cycle.
// Optional `RS_OLDEST_FIRST_EN: per-entry age, issue picks oldest ready entry instead of lowest index.
module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_v1,
    input  logic [DATA_W-1:0] in_v2,
    input  logic [TAG_W-1:0]  in_q1,
    input  logic [TAG_W-1:0]  in_q2,
    input  logic              in_r1,
    input  logic              in_r2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              full,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    output logic [OP_W-1:0]   op_to_alu,
    output logic [DATA_W-1:0] v1_to_alu,
    output logic [DATA_W-1:0] v2_to_alu,
    output logic [DATA_W-1:0] imm_to_alu,
    output logic [DATA_W-1:0] pc_to_alu,
    output logic [TAG_W-1:0]  tag_to_alu,
    output logic              is_empty_to_alu
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] r1_q, r1_d;
    logic [RS_SIZE-1:0] r2_q, r2_d;
    logic [RS_SIZE-1:0] ready;
    logic [OP_W-1:0]    op_q  [RS_SIZE];
    logic [DATA_W-1:0]  v1_q  [RS_SIZE];
    logic [DATA_W-1:0]  v1_d  [RS_SIZE];
    logic [DATA_W-1:0]  v2_q  [RS_SIZE];
    logic [DATA_W-1:0]  v2_d  [RS_SIZE];
    logic [DATA_W-1:0]  imm_q [RS_SIZE];
    logic [DATA_W-1:0]  pc_q  [RS_SIZE];
    logic [TAG_W-1:0]   q1_q  [RS_SIZE];
    logic [TAG_W-1:0]   q2_q  [RS_SIZE];
    logic [TAG_W-1:0]   tag_q [RS_SIZE];

    logic [IDX_W-1:0]  alloc_idx, iss_idx;
    logic              alloc_ok, iss_ok, do_alloc;
    logic              h1_0, h1_1, h2_0, h2_1;
    logic              new_r1, new_r2;
    logic [DATA_W-1:0] new_v1, new_v2;

    assign full     = &busy_q;
    assign ready    = busy_q & r1_q & r2_q;
    assign do_alloc = in_valid & alloc_ok;

    // Operands resolved on the CDB in the allocation cycle are captured directly
    assign h1_0   = cdb0_valid && (in_q1 == cdb0_tag);
    assign h1_1   = cdb1_valid && (in_q1 == cdb1_tag);
    assign h2_0   = cdb0_valid && (in_q2 == cdb0_tag);
    assign h2_1   = cdb1_valid && (in_q2 == cdb1_tag);
    assign new_r1 = in_r1 | h1_0 | h1_1;
    assign new_r2 = in_r2 | h2_0 | h2_1;
    assign new_v1 = in_r1 ? in_v1 : h1_0 ? cdb0_data : h1_1 ? cdb1_data : in_v1;
    assign new_v2 = in_r2 ? in_v2 : h2_0 ? cdb0_data : h2_1 ? cdb1_data : in_v2;

    always_comb begin
        alloc_idx = '0;
        alloc_ok  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = IDX_W'(i);
                alloc_ok  = 1'b1;
            end
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    logic [IDX_W-1:0] age_q [RS_SIZE];
    logic [IDX_W:0]   cnt;
    logic [IDX_W-1:0] age_new;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt = cnt + (IDX_W + 1)'(busy_q[i]);
        end
        age_new = IDX_W'(cnt) - IDX_W'(iss_ok);
    end

    always_comb begin
        iss_idx = '0;
        iss_ok  = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (!iss_ok || age_q[i] < age_q[iss_idx])) begin
                iss_idx = IDX_W'(i);
                iss_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
        end else if (rdy && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (iss_ok && busy_q[i] && age_q[i] > age_q[iss_idx])
                    age_q[i] <= age_q[i] - IDX_W'(1);
            end
            if (do_alloc) age_q[alloc_idx] <= age_new;
        end
    end
`else
    always_comb begin
        iss_idx = '0;
        iss_ok  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                iss_idx = IDX_W'(i);
                iss_ok  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        busy_d = busy_q;
        r1_d   = r1_q;
        r2_d   = r2_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            v1_d[i] = v1_q[i];
            v2_d[i] = v2_q[i];
            if (busy_q[i] && !r1_q[i]) begin
                if (cdb0_valid && q1_q[i] == cdb0_tag) begin
                    v1_d[i] = cdb0_data;
                    r1_d[i] = 1'b1;
                end else if (cdb1_valid && q1_q[i] == cdb1_tag) begin
                    v1_d[i] = cdb1_data;
                    r1_d[i] = 1'b1;
                end
            end
            if (busy_q[i] && !r2_q[i]) begin
                if (cdb0_valid && q2_q[i] == cdb0_tag) begin
                    v2_d[i] = cdb0_data;
                    r2_d[i] = 1'b1;
                end else if (cdb1_valid && q2_q[i] == cdb1_tag) begin
                    v2_d[i] = cdb1_data;
                    r2_d[i] = 1'b1;
                end
            end
        end
        if (iss_ok) busy_d[iss_idx] = 1'b0;
        if (do_alloc) begin
            busy_d[alloc_idx] = 1'b1;
            r1_d[alloc_idx]   = new_r1;
            r2_d[alloc_idx]   = new_r2;
            v1_d[alloc_idx]   = new_v1;
            v2_d[alloc_idx]   = new_v2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            r1_q            <= '0;
            r2_q            <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                tag_q[i] <= '0;
            end
            op_to_alu       <= '0;
            v1_to_alu       <= '0;
            v2_to_alu       <= '0;
            imm_to_alu      <= '0;
            pc_to_alu       <= '0;
            tag_to_alu      <= '0;
            is_empty_to_alu <= 1'b1;
        end else if (rdy) begin
            if (flush) begin
                busy_q          <= '0;
                is_empty_to_alu <= 1'b1;
            end else begin
                busy_q <= busy_d;
                r1_q   <= r1_d;
                r2_q   <= r2_d;
                for (int i = 0; i < RS_SIZE; i++) begin
                    v1_q[i] <= v1_d[i];
                    v2_q[i] <= v2_d[i];
                end
                if (do_alloc) begin
                    op_q[alloc_idx]  <= in_op;
                    imm_q[alloc_idx] <= in_imm;
                    pc_q[alloc_idx]  <= in_pc;
                    q1_q[alloc_idx]  <= in_q1;
                    q2_q[alloc_idx]  <= in_q2;
                    tag_q[alloc_idx] <= in_tag;
                end
                if (iss_ok) begin
                    op_to_alu       <= op_q[iss_idx];
                    v1_to_alu       <= v1_q[iss_idx];
                    v2_to_alu       <= v2_q[iss_idx];
                    imm_to_alu      <= imm_q[iss_idx];
                    pc_to_alu       <= pc_q[iss_idx];
                    tag_to_alu      <= tag_q[iss_idx];
                    is_empty_to_alu <= 1'b0;
                end else begin
                    is_empty_to_alu <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: directed scenarios plus random traffic
// checked against a slot/sequence-number reference model.
module tb_alu_reservation_station;

    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_XOR = 6'd5;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_v1, in_v2, in_imm, in_pc;
    logic [3:0]  in_q1, in_q2, in_tag;
    logic        in_r1, in_r2;
    logic        full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic [5:0]  op_to_alu;
    logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
    logic [3:0]  tag_to_alu;
    logic        is_empty_to_alu;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_op(in_op),
        .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
        .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm), .in_pc(in_pc),
        .in_tag(in_tag), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
        .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
        .tag_to_alu(tag_to_alu), .is_empty_to_alu(is_empty_to_alu)
    );

    typedef struct {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm, pc;
        logic [3:0]  q1, q2, tag;
        logic        r1, r2;
        int unsigned seq;
    } rs_ent_t;

    rs_ent_t     m [16];
    int unsigned seq_ctr;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_tag;
    logic        e_empty;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; cdb0_valid = 0; cdb1_valid = 0;
    endtask

    task automatic drive_alloc(input logic [5:0] op, input logic [31:0] v1,
                               input logic [31:0] v2, input logic [3:0] q1,
                               input logic [3:0] q2, input logic r1,
                               input logic r2, input logic [3:0] tag);
        in_valid = 1; in_op = op; in_v1 = v1; in_v2 = v2;
        in_q1 = q1; in_q2 = q2; in_r1 = r1; in_r2 = r2;
        in_imm = {28'h0, tag} + 32'h100; in_pc = {28'h0, tag} << 2;
        in_tag = tag;
    endtask

    // Reference model: one abstract clock edge using the inputs currently driven
    task automatic model_edge();
        rs_ent_t nx [16];
        int sel, fs;
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            e_empty = 1;
            return;
        end
        sel = -1; fs = -1;
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef RS_OLDEST_FIRST_EN
                if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
            if (!m[i].busy && fs < 0) fs = i;
        end
        nx = m;
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy && !m[i].r1) begin
                if (cdb0_valid && m[i].q1 == cdb0_tag) begin nx[i].v1 = cdb0_data; nx[i].r1 = 1; end
                else if (cdb1_valid && m[i].q1 == cdb1_tag) begin nx[i].v1 = cdb1_data; nx[i].r1 = 1; end
            end
            if (m[i].busy && !m[i].r2) begin
                if (cdb0_valid && m[i].q2 == cdb0_tag) begin nx[i].v2 = cdb0_data; nx[i].r2 = 1; end
                else if (cdb1_valid && m[i].q2 == cdb1_tag) begin nx[i].v2 = cdb1_data; nx[i].r2 = 1; end
            end
        end
        if (sel >= 0) begin
            e_op = m[sel].op; e_v1 = m[sel].v1; e_v2 = m[sel].v2;
            e_imm = m[sel].imm; e_pc = m[sel].pc; e_tag = m[sel].tag;
            e_empty = 0;
            nx[sel].busy = 0;
        end else begin
            e_empty = 1;
        end
        if (in_valid && fs >= 0) begin
            nx[fs].busy = 1; nx[fs].op = in_op; nx[fs].imm = in_imm;
            nx[fs].pc = in_pc; nx[fs].tag = in_tag;
            nx[fs].q1 = in_q1; nx[fs].q2 = in_q2;
            nx[fs].r1 = in_r1; nx[fs].v1 = in_v1;
            nx[fs].r2 = in_r2; nx[fs].v2 = in_v2;
            if (!in_r1 && cdb0_valid && in_q1 == cdb0_tag) begin nx[fs].v1 = cdb0_data; nx[fs].r1 = 1; end
            else if (!in_r1 && cdb1_valid && in_q1 == cdb1_tag) begin nx[fs].v1 = cdb1_data; nx[fs].r1 = 1; end
            if (!in_r2 && cdb0_valid && in_q2 == cdb0_tag) begin nx[fs].v2 = cdb0_data; nx[fs].r2 = 1; end
            else if (!in_r2 && cdb1_valid && in_q2 == cdb1_tag) begin nx[fs].v2 = cdb1_data; nx[fs].r2 = 1; end
            nx[fs].seq = seq_ctr;
            seq_ctr++;
        end
        m = nx;
    endtask

    task automatic test_reset();
        rst = 1; rdy = 1; idle();
        drive_alloc(6'd0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
        cdb0_tag = 0; cdb1_tag = 0; cdb0_data = 0; cdb1_data = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL reset_empty got=%b want=1", is_empty_to_alu); end
        n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b want=0", full); end
        n_cmp++; if ({op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu, tag_to_alu} !== '0) begin
            n_bad++; $display("FAIL reset_outputs op=%h v1=%h tag=%h want all zero", op_to_alu, v1_to_alu, tag_to_alu); end
        rst = 0;
        step();
    endtask

    task automatic test_ready_issue();
        drive_alloc(OP_ADD, 5, 7, 0, 0, 1, 1, 3);
        step();
        idle();
        n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL ready_latency got_empty=%b want=1", is_empty_to_alu); end
        step();
        n_cmp++; if (is_empty_to_alu !== 1'b0) begin n_bad++; $display("FAIL ready_issue_empty got=%b want=0", is_empty_to_alu); end
        n_cmp++; if ({op_to_alu, v1_to_alu, v2_to_alu, tag_to_alu} !== {OP_ADD, 32'd5, 32'd7, 4'd3}) begin
            n_bad++; $display("FAIL ready_issue_fields op=%h v1=%h v2=%h tag=%h want 01/5/7/3", op_to_alu, v1_to_alu, v2_to_alu, tag_to_alu); end
        n_cmp++; if ({imm_to_alu, pc_to_alu} !== {32'h103, 32'hC}) begin
            n_bad++; $display("FAIL ready_issue_immpc imm=%h pc=%h want 103/c", imm_to_alu, pc_to_alu); end
        step();
        n_cmp++; if (is_empty_to_alu !== 1'b1 || op_to_alu !== OP_ADD) begin
            n_bad++; $display("FAIL ready_after empty=%b op=%h want 1/01", is_empty_to_alu, op_to_alu); end
    endtask

    task automatic test_cdb_resolve();
        drive_alloc(OP_SUB, 0, 3, 2, 0, 0, 1, 4);
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL cdb_wait%0d got_empty=%b want=1", k, is_empty_to_alu); end
        end
        cdb1_valid = 1; cdb1_tag = 2; cdb1_data = 32'h10;
        step();
        idle();
        n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL cdb_same_cycle got_empty=%b want=1", is_empty_to_alu); end
        step();
        n_cmp++; if ({is_empty_to_alu, op_to_alu, v1_to_alu, v2_to_alu, tag_to_alu} !== {1'b0, OP_SUB, 32'h10, 32'd3, 4'd4}) begin
            n_bad++; $display("FAIL cdb_issue empty=%b op=%h v1=%h v2=%h tag=%h want 0/02/10/3/4",
                              is_empty_to_alu, op_to_alu, v1_to_alu, v2_to_alu, tag_to_alu); end
        step();
    endtask

    task automatic test_alloc_bypass();
        drive_alloc(OP_ADD, 1, 0, 0, 6, 1, 0, 7);
        cdb0_valid = 1; cdb0_tag = 6; cdb0_data = 32'hABCD;
        step();
        idle();
        step();
        n_cmp++; if ({is_empty_to_alu, v2_to_alu, tag_to_alu} !== {1'b0, 32'hABCD, 4'd7}) begin
            n_bad++; $display("FAIL bypass empty=%b v2=%h tag=%h want 0/abcd/7", is_empty_to_alu, v2_to_alu, tag_to_alu); end
        step();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(OP_ADD, 0, 1, 4'(i), 0, 0, 1, 4'(i));
            step();
        end
        idle();
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_set got=%b want=1", full); end
        drive_alloc(OP_XOR, 9, 9, 0, 0, 1, 1, 14);
        step();
        idle();
        step();
        n_cmp++; if (is_empty_to_alu !== 1'b1 || full !== 1'b1) begin
            n_bad++; $display("FAIL full_ignore empty=%b full=%b want 1/1", is_empty_to_alu, full); end
        cdb0_valid = 1; cdb0_tag = 5; cdb0_data = 32'h55;
        step();
        idle();
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_before_issue got=%b want=1", full); end
        step();
        n_cmp++; if ({is_empty_to_alu, tag_to_alu, v1_to_alu, full} !== {1'b0, 4'd5, 32'h55, 1'b0}) begin
            n_bad++; $display("FAIL full_issue empty=%b tag=%h v1=%h full=%b want 0/5/55/0",
                              is_empty_to_alu, tag_to_alu, v1_to_alu, full); end
        flush = 1;
        step();
        idle();
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 5; i++) begin
            drive_alloc(OP_ADD, 0, 2, 4'(i), 0, 0, 1, 4'(i + 8));
            step();
        end
        drive_alloc(OP_XOR, 1, 1, 0, 0, 1, 1, 9);
        flush = 1; cdb0_valid = 1; cdb0_tag = 3; cdb0_data = 32'h33;
        step();
        idle();
        n_cmp++; if ({is_empty_to_alu, full, tag_to_alu} !== {1'b1, 1'b0, 4'd5}) begin
            n_bad++; $display("FAIL flush_state empty=%b full=%b tag=%h want 1/0/5", is_empty_to_alu, full, tag_to_alu); end
        for (int t = 1; t <= 7; t++) begin
            cdb0_valid = (t <= 5); cdb0_tag = 4'(t); cdb0_data = 32'(t);
            step();
            n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL flush_stale%0d got_empty=%b want=1", t, is_empty_to_alu); end
        end
        idle();
    endtask

    task automatic test_oldest();
        logic [3:0] first, second;
`ifdef RS_OLDEST_FIRST_EN
        first = 4'd11; second = 4'd12;
`else
        first = 4'd12; second = 4'd11;
`endif
        drive_alloc(OP_ADD, 0, 1, 1, 0, 0, 1, 10);
        step();
        drive_alloc(OP_SUB, 0, 1, 2, 0, 0, 1, 11);
        step();
        idle(); cdb0_valid = 1; cdb0_tag = 1; cdb0_data = 32'hA;
        step();
        idle();
        step();
        n_cmp++; if ({is_empty_to_alu, tag_to_alu} !== {1'b0, 4'd10}) begin
            n_bad++; $display("FAIL oldest_a empty=%b tag=%h want 0/a", is_empty_to_alu, tag_to_alu); end
        drive_alloc(OP_XOR, 3, 4, 0, 0, 1, 1, 12);
        cdb0_valid = 1; cdb0_tag = 2; cdb0_data = 32'hB;
        step();
        idle();
        step();
        n_cmp++; if ({is_empty_to_alu, tag_to_alu} !== {1'b0, first}) begin
            n_bad++; $display("FAIL order_first empty=%b tag=%h want 0/%h", is_empty_to_alu, tag_to_alu, first); end
        step();
        n_cmp++; if ({is_empty_to_alu, tag_to_alu} !== {1'b0, second}) begin
            n_bad++; $display("FAIL order_second empty=%b tag=%h want 0/%h", is_empty_to_alu, tag_to_alu, second); end
        step();
        n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL order_drained got_empty=%b want=1", is_empty_to_alu); end
    endtask

    task automatic test_async_reset();
        drive_alloc(OP_ADD, 0, 1, 1, 0, 0, 1, 3);
        step();
        idle();
        #2 rst = 1;
        #1;
        n_cmp++; if ({is_empty_to_alu, op_to_alu, tag_to_alu, full} !== {1'b1, 6'd0, 4'd0, 1'b0}) begin
            n_bad++; $display("FAIL async_reset empty=%b op=%h tag=%h full=%b want 1/0/0/0",
                              is_empty_to_alu, op_to_alu, tag_to_alu, full); end
        #1 rst = 0;
        cdb0_valid = 1; cdb0_tag = 1; cdb0_data = 32'h77;
        step();
        idle();
        step();
        n_cmp++; if (is_empty_to_alu !== 1'b1) begin n_bad++; $display("FAIL async_reset_gone got_empty=%b want=1", is_empty_to_alu); end
    endtask

    task automatic test_random();
        logic mfull;
        rst = 1; idle();
        #2 rst = 0;
        step();
        for (int i = 0; i < 16; i++) m[i].busy = 0;
        seq_ctr = 0;
        e_op = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_tag = 0; e_empty = 1;
        for (int c = 0; c < 800; c++) begin
            mfull = 1;
            for (int i = 0; i < 16; i++) if (!m[i].busy) mfull = 0;
            n_cmp++; if (full !== mfull) begin n_bad++; $display("FAIL rand_full cyc=%0d got=%b want=%b", c, full, mfull); end
            rdy = ($urandom_range(9) != 0);
            flush = ($urandom_range(49) == 0);
            in_valid = !mfull && ($urandom_range(2) != 0);
            in_op = 6'($urandom); in_v1 = $urandom; in_v2 = $urandom;
            in_q1 = 4'($urandom_range(3)); in_q2 = 4'($urandom_range(3));
            in_r1 = 1'($urandom); in_r2 = 1'($urandom);
            in_imm = $urandom; in_pc = $urandom; in_tag = 4'($urandom);
            cdb0_valid = ($urandom_range(2) == 0); cdb0_tag = 4'($urandom_range(3)); cdb0_data = $urandom;
            cdb1_valid = ($urandom_range(2) == 0); cdb1_tag = 4'($urandom_range(3)); cdb1_data = $urandom;
            if (cdb0_valid && cdb1_valid && cdb0_tag == cdb1_tag) cdb1_tag = (cdb0_tag + 4'd1) & 4'd3;
            model_edge();
            step();
            n_cmp++; if (is_empty_to_alu !== e_empty) begin
                n_bad++; $display("FAIL rand_empty cyc=%0d got=%b want=%b", c, is_empty_to_alu, e_empty); end
            n_cmp++; if ({op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu, tag_to_alu} !==
                          {e_op, e_v1, e_v2, e_imm, e_pc, e_tag}) begin
                n_bad++; $display("FAIL rand_payload cyc=%0d got op=%h v1=%h v2=%h imm=%h pc=%h tag=%h want op=%h v1=%h v2=%h imm=%h pc=%h tag=%h",
                                  c, op_to_alu, v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu, tag_to_alu,
                                  e_op, e_v1, e_v2, e_imm, e_pc, e_tag); end
        end
        rdy = 1; idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ready_issue();
        test_cdb_resolve();
        test_alloc_bypass();
        test_full();
        test_flush();
        test_oldest();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
